stp_frame_buffer: RTL
=====================

STP_FRAME_BUFFER -- requirements
Module: stp_frame_buffer

Interface
REQ-001 Parameter DATA_W, default 16: sample width in bits.
REQ-002 Parameter DEPTH, default 64: samples per frame; SHALL be >= 2.
REQ-003 clk  input  1: single clock; all logic SHALL be clocked on the rising edge.
REQ-004 rst  input  1: reset, synchronous, active-high.
REQ-005 in_valid  input  1: in_data holds a valid sample.
REQ-006 in_data  input  DATA_W: serial sample.
REQ-007 in_ready  output  1: block accepts a sample this cycle.
REQ-008 abort  input  1: discard the partially or fully assembled, not-yet-transferred frame.
REQ-009 frame_valid  output  1: frame_data holds a complete frame.
REQ-010 frame_ready  input  1: consumer takes frame_data this cycle.
REQ-011 frame_data  output  DEPTH x DATA_W: parallel frame, element k is DATA_W wide.
REQ-012 fill_cnt  output  clog2(DEPTH+1): samples held in the assembly register.

Function
REQ-013 accept = in_valid & in_ready; consume = frame_valid & frame_ready.
REQ-014 The block SHALL have two stages: a shift-assembly register (DEPTH x DATA_W) and an output slot (frame_data/frame_valid).
REQ-015 On accept, the assembly register SHALL shift toward index 0 with in_data entering at index DEPTH-1, and fill_cnt SHALL increment.
REQ-016 The FSM SHALL have two states: FILL (in_ready=1) and HOLD (in_ready=0); in_ready SHALL depend only on state and rst, never on frame_ready.
REQ-017 slot_free = !frame_valid | frame_ready.
REQ-018 FILL with accept of the DEPTH-th sample and slot_free: the output slot SHALL load the completed frame including in_data on that edge, frame_valid=1 next cycle, fill_cnt->0, state remains FILL; there SHALL be no bubble.
REQ-019 FILL with accept of the DEPTH-th sample and !slot_free: the assembly register SHALL hold the full frame, fill_cnt=DEPTH, state->HOLD.
REQ-020 HOLD with slot_free: the assembly contents SHALL transfer to the slot, fill_cnt->0, state->FILL; in_ready=1 on the following cycle.
REQ-021 consume without a simultaneous transfer SHALL clear frame_valid next cycle; consume with a simultaneous transfer SHALL keep frame_valid=1 with the new frame.
REQ-022 frame_data SHALL be stable while frame_valid=1 and frame_ready=0.
REQ-023 abort SHALL force fill_cnt->0 and state->FILL, and SHALL override a same-cycle accept or transfer; it SHALL NOT alter the output slot. Assembly data after abort is don't-care.
REQ-024 fill_cnt SHALL never exceed DEPTH; in_valid while in_ready=0 SHALL be ignored.

Reset
REQ-025 While rst=1 at a rising edge: state=FILL, fill_cnt=0, frame_valid=0, frame_data all zero, assembly register all zero.
REQ-026 in_ready SHALL be 0 while rst=1 and 1 on the first cycle after rst deasserts.
REQ-027 Reset mid-frame SHALL discard both the partial frame and any pending output frame.

Configuration
REQ-028 Macro STP_BIT_REVERSE_EN: when defined, frame_data[k] SHALL equal the sample accepted at frame position bitrev(k) over log2(DEPTH) bits, and DEPTH SHALL be a power of two (elaboration error otherwise).
REQ-029 Without STP_BIT_REVERSE_EN: frame_data[k] SHALL equal the k-th sample accepted in the frame (k from 0), and any DEPTH >= 2 SHALL be legal.

Verification (DATA_W=16, DEPTH=8)
REQ-030 Reset, then 8 accepts of 0x0001..0x0008 with frame_ready=1 -> frame_valid=1 one cycle after the 8th accept, frame_data[0..7]=0x0001..0x0008, fill_cnt=0.
REQ-031 Continuous in_valid for 16 samples with frame_ready=1 -> two frames delivered, in_ready never drops, second frame appears exactly 8 cycles after the first.
REQ-032 frame_ready=0, 16 samples offered -> the first frame is held stable; after the second frame's 8th accept, state=HOLD, in_ready=0, fill_cnt=8; raise frame_ready -> the second frame loads next cycle and in_ready=1 the cycle after.
REQ-033 abort asserted after 5 accepts, together with a 6th in_valid -> fill_cnt=0, the 6th sample is discarded, and the next 8 samples form a clean frame.
REQ-034 With STP_BIT_REVERSE_EN, samples 0x0000..0x0007 -> frame_data = 0,4,2,6,1,5,3,7.
REQ-035 rst pulsed with fill_cnt=3 and frame_valid=1 -> next cycle frame_valid=0, fill_cnt=0, frame_data=0.

Source files
------------

// File: rtl/stp_frame_buffer.sv
// Serial-to-parallel frame buffer: shift-assembly register feeding a one-frame output slot.
// Optional macro STP_BIT_REVERSE_EN delivers each frame in bit-reversed sample order.
module stp_frame_buffer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [DATA_W-1:0]              in_data,
    output logic                           in_ready,
    input  logic                           abort,
    output logic                           frame_valid,
    input  logic                           frame_ready,
    output logic [DEPTH-1:0][DATA_W-1:0]   frame_data,
    output logic [$clog2(DEPTH+1)-1:0]     fill_cnt
);

    localparam int CW = $clog2(DEPTH+1);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                         state;
    logic [DEPTH-1:0][DATA_W-1:0]   asm_q;
    logic [DEPTH-1:0][DATA_W-1:0]   shifted;
    logic [DEPTH-1:0][DATA_W-1:0]   src;
    logic [DEPTH-1:0][DATA_W-1:0]   ordered;
    logic                           accept;
    logic                           consume;
    logic                           slot_free;
    logic                           last;
    logic                           transfer;

    assign in_ready  = !rst && (state == FILL);
    assign accept    = in_valid && in_ready;
    assign consume   = frame_valid && frame_ready;
    assign slot_free = !frame_valid || frame_ready;
    assign last      = (fill_cnt == CW'(DEPTH-1));

    // Newest sample enters at the top so the oldest ends up at index 0.
    assign shifted = {in_data, asm_q[DEPTH-1:1]};

    // Completing sample bypasses the assembly register so a full frame loads with no bubble.
    assign src = (state == HOLD) ? asm_q : shifted;

    assign transfer = !abort && slot_free &&
                      ((state == HOLD) || (accept && last));

`ifdef STP_BIT_REVERSE_EN
    localparam int AW = $clog2(DEPTH);

    if ((1 << AW) != DEPTH) begin : g_pow2_check
        $error("stp_frame_buffer: DEPTH must be a power of two with STP_BIT_REVERSE_EN");
    end

    function automatic int unsigned bitrev(input int unsigned k);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < AW; i++) begin
            if (((k >> i) & 1) != 0) r = r | (1 << (AW - 1 - i));
        end
        return r;
    endfunction

    for (genvar k = 0; k < DEPTH; k++) begin : g_rev
        localparam int unsigned R = bitrev(k);
        assign ordered[k] = src[R];
    end
`else
    assign ordered = src;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            fill_cnt    <= '0;
            frame_valid <= 1'b0;
            frame_data  <= '0;
            asm_q       <= '0;
        end else begin
            if (transfer) begin
                frame_data  <= ordered;
                frame_valid <= 1'b1;
            end else if (consume) begin
                frame_valid <= 1'b0;
            end

            if (abort) begin
                state    <= FILL;
                fill_cnt <= '0;
            end else if (state == HOLD) begin
                if (slot_free) begin
                    state    <= FILL;
                    fill_cnt <= '0;
                end
            end else if (accept) begin
                asm_q <= shifted;
                if (last && slot_free) begin
                    fill_cnt <= '0;
                end else begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (last) state <= HOLD;
                end
            end
        end
    end

endmodule
